multichannel_sram: RTL and testbench
====================================

MULTICHANNEL_SRAM -- requirements
Module: multichannel_sram

Interface
REQ-001 Parameter data_width, default 16, word width in bits.
REQ-002 Parameter bank_size, default 1024, words per bank; a power of 2.
REQ-003 Parameter n_banks, default 8, bank count; a power of 2.
REQ-004 Parameter n_read_ch, default 4, independent read channels, 1..8.
REQ-005 Parameter addr_width, default $clog2(bank_size*n_banks), address width.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rd_req  in  n_read_ch  per-channel read request; bit k is held until rd_grant[k] is seen.
REQ-009 rd_addr  in  n_read_ch*addr_width  packed addresses; channel k at bits [k*addr_width +: addr_width].
REQ-010 rd_grant  out  n_read_ch  combinational; one-hot or zero; request accepted at the next edge.
REQ-011 rd_valid  out  n_read_ch  registered, one-hot or zero; rd_data belongs to the flagged channel.
REQ-012 rd_data  out  data_width  read result, qualified by rd_valid.
REQ-013 rd_invalid  out  1  pulses with rd_valid when that read was out of range.
REQ-014 wr_req, wr_addr, wr_data  in  1/addr_width/data_width  write request, address and data.
REQ-015 wr_ready  out  1  registered; 1 whenever not in reset.
REQ-016 wr_invalid  out  1  one-cycle pulse on the cycle after an out-of-range write is accepted.

Function
REQ-017 Address split: bank = addr[BANK_OFF_W +: BANK_ADDR_W], offset = addr[BANK_OFF_W-1:0]; out of range = addr >= n_banks*bank_size.
REQ-018 Round-robin arbiter: priority pointer p, reset value 0; grant the first requesting channel scanning p, p+1, ... mod n_read_ch.
REQ-019 After a grant to channel k, p becomes (k+1) mod n_read_ch; with no grant, p holds.
REQ-020 At most one read is granted per cycle; throughput is one read per cycle with no bubbles.
REQ-021 Read latency is fixed: rd_valid[k] asserts exactly 2 cycles after the edge that accepted the grant (bank read stage, then output register).
REQ-022 Up to 2 reads are in flight; the channel tag travels with each read through the pipeline.
REQ-023 Out-of-range read: still granted; completes at normal latency with rd_data = 0 and rd_invalid = 1.
REQ-024 A write is accepted on any edge with wr_req && wr_ready and commits to memory at that edge.
REQ-025 Out-of-range write: dropped, memory unchanged; wr_invalid pulses on the next cycle.
REQ-026 Reads and writes are independent; a read and a write may be accepted on the same edge.
REQ-027 A write accepted 1 or more cycles before a read's grant edge is visible to that read.
REQ-028 Same-edge read and write to the same in-range address: behaviour is set by REQ-033/REQ-034.
REQ-029 rd_valid, rd_invalid and wr_invalid are never asserted except as specified above.

Reset
REQ-030 Reset assertion (reset = 0) clears, asynchronously: p = 0, rd_valid = 0, rd_invalid = 0, rd_data = 0, wr_invalid = 0, wr_ready = 0; rd_grant = 0 while reset is asserted.
REQ-031 Reads in flight when reset asserts are discarded; no rd_valid is produced for them after release. Memory contents are not cleared.
REQ-032 wr_ready rises on the first edge after reset is released.

Configuration
REQ-033 With macro SRAM_RAW_BYPASS_EN defined, the read in REQ-028 returns the new wr_data (write forwarding, carried through the read pipeline).
REQ-034 Without SRAM_RAW_BYPASS_EN, the read in REQ-028 returns the old memory contents; no forwarding logic is present.

Verification
REQ-035 Write 0xA5A5 to address 0x0003, then channel 0 reads 0x0003 -> rd_valid = 4'b0001 two cycles after the grant, rd_data = 0xA5A5.
REQ-036 All 4 channels request every cycle from reset -> grants in order 0,1,2,3,0,...; rd_valid follows the same order, one per cycle, with no gaps.
REQ-037 Channel 2 reads 0x2000 (8192, out of range) -> grant given; two cycles later rd_valid = 4'b0100, rd_data = 0, rd_invalid = 1; a write to 0x2000 -> wr_invalid pulses once and memory is unchanged.
REQ-038 Address 0x0010 holds 0x1111; on the same edge, write 0x2222 to 0x0010 and grant a read of 0x0010 -> rd_data = 0x2222 with SRAM_RAW_BYPASS_EN, 0x1111 without it.
REQ-039 Grant channel 1, assert reset 1 cycle later, release it -> no rd_valid for channel 1 and p = 0; earlier writes are still readable.

Source files
------------

// File: rtl/multichannel_sram.sv
// Banked single-write / multi-channel-read SRAM with a round-robin read arbiter and a fixed 2-cycle read pipeline.
// Optional macro SRAM_RAW_BYPASS_EN forwards same-edge write data to a read of the same address.
module multichannel_sram #(
  parameter int data_width = 16,
  parameter int bank_size  = 1024,
  parameter int n_banks    = 8,
  parameter int n_read_ch  = 4,
  parameter int addr_width = $clog2(bank_size * n_banks)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [n_read_ch-1:0]            rd_req,
  input  logic [n_read_ch*addr_width-1:0] rd_addr,
  output logic [n_read_ch-1:0]            rd_grant,
  output logic [n_read_ch-1:0]            rd_valid,
  output logic [data_width-1:0]           rd_data,
  output logic                            rd_invalid,
  input  logic                            wr_req,
  input  logic [addr_width-1:0]           wr_addr,
  input  logic [data_width-1:0]           wr_data,
  output logic                            wr_ready,
  output logic                            wr_invalid
);

  localparam int BANK_OFF_W  = $clog2(bank_size);
  localparam int BANK_ADDR_W = $clog2(n_banks);
  localparam int PTR_W       = (n_read_ch > 1) ? $clog2(n_read_ch) : 1;
  localparam int unsigned N_WORDS = bank_size * n_banks;
  localparam logic [addr_width:0] LIMIT = (addr_width + 1)'(N_WORDS);

  function automatic logic out_of_range(input logic [addr_width-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  logic [data_width-1:0] mem [n_banks][bank_size];

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand;
  logic                  gnt_any;
  logic [addr_width-1:0] ch_addr [n_read_ch];
  logic [addr_width-1:0] gnt_addr;
  logic                  gnt_oor;
  logic                  wr_acc;
  logic                  wr_oor;
  int                    c;

  logic                  s1_valid, s1_oor;
  logic [n_read_ch-1:0]  s1_ch;
  logic [data_width-1:0] s1_data;
  logic                  s2_valid, s2_oor;
  logic [n_read_ch-1:0]  s2_ch;
  logic [data_width-1:0] s2_data;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    c       = 0;
    for (int i = 0; i < n_read_ch; i++) begin
      c = int'(ptr) + i;
      if (c >= n_read_ch) c = c - n_read_ch;
      cand = PTR_W'(c);
      if (!gnt_any && rd_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!reset) gnt_any = 1'b0;
  end

  always_comb begin
    rd_grant = '0;
    if (gnt_any) rd_grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < n_read_ch; i++) ch_addr[i] = rd_addr[i*addr_width +: addr_width];
  end

  assign gnt_addr = ch_addr[gnt_idx];
  assign gnt_oor  = out_of_range(gnt_addr);
  assign wr_acc   = wr_req && wr_ready;
  assign wr_oor   = out_of_range(wr_addr);

  // NOTE: the storage array and its read register have no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_acc && !wr_oor)
      mem[wr_addr[BANK_OFF_W +: BANK_ADDR_W]][wr_addr[BANK_OFF_W-1:0]] <= wr_data;
`ifdef SRAM_RAW_BYPASS_EN
    if (gnt_any) begin
      if (wr_acc && !wr_oor && (wr_addr == gnt_addr))
        s1_data <= wr_data;
      else
        s1_data <= mem[gnt_addr[BANK_OFF_W +: BANK_ADDR_W]][gnt_addr[BANK_OFF_W-1:0]];
    end
`else
    // Same-edge write is not yet in the array when this read samples it: old data returned.
    if (gnt_any)
      s1_data <= mem[gnt_addr[BANK_OFF_W +: BANK_ADDR_W]][gnt_addr[BANK_OFF_W-1:0]];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      s1_valid   <= 1'b0;
      s1_oor     <= 1'b0;
      s1_ch      <= '0;
      s2_valid   <= 1'b0;
      s2_oor     <= 1'b0;
      s2_ch      <= '0;
      s2_data    <= '0;
      rd_valid   <= '0;
      rd_data    <= '0;
      rd_invalid <= 1'b0;
      wr_ready   <= 1'b0;
      wr_invalid <= 1'b0;
    end else begin
      if (gnt_any) begin
        if (gnt_idx == PTR_W'(n_read_ch - 1)) ptr <= '0;
        else                                  ptr <= gnt_idx + 1'b1;
      end
      s1_valid   <= gnt_any;
      s1_oor     <= gnt_oor;
      s1_ch      <= rd_grant;
      s2_valid   <= s1_valid;
      s2_oor     <= s1_oor;
      s2_ch      <= s1_ch;
      s2_data    <= s1_data;
      rd_valid   <= s2_valid ? s2_ch : '0;
      rd_data    <= (s2_valid && !s2_oor) ? s2_data : '0;
      rd_invalid <= s2_valid && s2_oor;
      wr_ready   <= 1'b1;
      wr_invalid <= wr_acc && wr_oor;
    end
  end

endmodule

// File: tb/tb_multichannel_sram.sv
// Randomized self-checking bench for multichannel_sram against an array/queue reference model.
// A 14-bit address is used so out-of-range addresses (>= 8192) can be driven.
module tb_multichannel_sram;
  localparam int DW = 16;
  localparam int BS = 1024;
  localparam int NB = 8;
  localparam int NCH = 4;
  localparam int AW = 14;
  localparam int WORDS = BS * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NCH-1:0]      rd_req;
  logic [NCH*AW-1:0]   rd_addr;
  logic [NCH-1:0]      rd_grant;
  logic [NCH-1:0]      rd_valid;
  logic [DW-1:0]       rd_data;
  logic                rd_invalid;
  logic                wr_req;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                wr_ready;
  logic                wr_invalid;

  multichannel_sram #(
    .data_width(DW), .bank_size(BS), .n_banks(NB), .n_read_ch(NCH), .addr_width(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_invalid(rd_invalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_invalid(wr_invalid)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: flat word array, priority pointer, queue of expected completions.
  typedef struct {
    int           due;
    int           ch;
    logic [DW-1:0] data;
    bit           inv;
  } rd_exp_t;

  logic [DW-1:0] mem_m [WORDS];
  rd_exp_t       exp_q[$];
  int            p_m;
  bit            wr_ready_m;
  bit            wr_inv_m;
  int            cyc;
  int            last_g;

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    int      g;
    int      a;
    int      c;
    bit      wr_acc;
    rd_exp_t e;
    #1;
    g = -1;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        c = (p_m + i) % NCH;
        if (g < 0 && rd_req[c]) g = c;
      end
    end
    check("grant", 32'(rd_grant), (g < 0) ? 32'd0 : (32'd1 << g));
    last_g = g;
    @(posedge clk);
    cyc++;
    wr_acc = wr_req && wr_ready_m;
    if (g >= 0) begin
      a     = int'(rd_addr[g*AW +: AW]);
      e.due = cyc + 2;
      e.ch  = g;
      e.inv = (a >= WORDS);
      if (e.inv) e.data = '0;
      else begin
        e.data = mem_m[a];
`ifdef SRAM_RAW_BYPASS_EN
        if (wr_acc && int'(wr_addr) == a) e.data = wr_data;
`endif
      end
      exp_q.push_back(e);
      p_m = (g + 1) % NCH;
    end
    wr_inv_m = wr_acc && (int'(wr_addr) >= WORDS);
    if (wr_acc && int'(wr_addr) < WORDS) mem_m[int'(wr_addr)] = wr_data;
    wr_ready_m = 1'b1;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("rd_valid", 32'(rd_valid), 32'd1 << e.ch);
      check("rd_data", 32'(rd_data), 32'(e.data));
      check("rd_invalid", 32'(rd_invalid), 32'(e.inv));
    end else begin
      check("rd_valid_idle", 32'(rd_valid), 32'd0);
      check("rd_invalid_idle", 32'(rd_invalid), 32'd0);
    end
    check("wr_invalid", 32'(wr_invalid), 32'(wr_inv_m));
    check("wr_ready", 32'(wr_ready), 32'(wr_ready_m));
    @(negedge clk);
  endtask

  task automatic apply_reset(input int hold);
    reset = 1'b0;
    exp_q.delete();
    p_m = 0;
    wr_ready_m = 1'b0;
    wr_inv_m = 1'b0;
    rd_req = '1;
    #1;
    check("rst_grant", 32'(rd_grant), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_invalid", 32'(rd_invalid), 32'd0);
    check("rst_wr_invalid", 32'(wr_invalid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (hold) @(negedge clk);
    rd_req = '0;
    reset = 1'b1;
  endtask

  task automatic set_rd(input int ch, input int addr);
    rd_req[ch] = 1'b1;
    rd_addr[ch*AW +: AW] = AW'(addr);
  endtask

  task automatic set_wr(input int addr, input int data);
    wr_req  = 1'b1;
    wr_addr = AW'(addr);
    wr_data = DW'(data);
  endtask

  task automatic idle(input int n);
    rd_req = '0;
    wr_req = 1'b0;
    repeat (n) cycle();
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 9) == 0) return WORDS + int'($urandom_range(0, WORDS - 1));
    return int'($urandom_range(0, 63));
  endfunction

  initial begin
    reset = 1'b0; rd_req = '0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    cyc = 0; last_g = -1;
    @(negedge clk);
    apply_reset(2);

    // wr_ready is still low in the first cycle after release.
    idle(1);
    set_wr(3, 16'hA5A5); cycle();
    wr_req = 1'b0;
    set_rd(0, 3); cycle();
    idle(3);

    // Fill the working range; 0x10 gets a known value.
    for (int a = 0; a < 64; a++) begin
      set_wr(a, (a == 16) ? 16'h1111 : int'($urandom_range(0, 65535)));
      cycle();
    end
    idle(1);

    // All channels requesting continuously from reset: strict rotation, back-to-back results.
    apply_reset(1);
    for (int k = 0; k < NCH; k++) set_rd(k, int'($urandom_range(0, 63)));
    repeat (12) begin
      cycle();
      if (last_g >= 0) rd_addr[last_g*AW +: AW] = AW'($urandom_range(0, 63));
    end
    idle(3);

    // Out-of-range read and write; 0x2000 aliases word 0, which must stay unchanged.
    set_rd(2, 16'h2000); cycle();
    rd_req = '0;
    set_wr(16'h2000, 16'hDEAD); cycle();
    wr_req = 1'b0;
    set_rd(1, 0); cycle();
    idle(3);

    // Same-edge write and read of 0x10.
    set_rd(0, 16'h10);
    set_wr(16'h10, 16'h2222);
    cycle();
    idle(3);

    // Reset with a read in flight: it is discarded, pointer returns to 0, memory kept.
    set_rd(1, 3); cycle();
    idle(1);
    apply_reset(2);
    idle(4);
    for (int k = 0; k < NCH; k++) set_rd(k, 3 + k);
    cycle();
    idle(3);

    // Randomized traffic with held requests.
    rd_req = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NCH; k++) begin
        if (last_g == k) rd_req[k] = 1'b0;
        if (!rd_req[k] && $urandom_range(0, 1) == 1) set_rd(k, rand_addr());
      end
      wr_req = 1'($urandom_range(0, 1));
      wr_addr = AW'(rand_addr());
      wr_data = DW'($urandom_range(0, 65535));
      cycle();
    end
    for (int k = 0; k < NCH; k++) if (last_g == k) rd_req[k] = 1'b0;
    wr_req = 1'b0;
    // Let outstanding requests drain before idling.
    repeat (8) begin
      cycle();
      for (int k = 0; k < NCH; k++) if (last_g == k) rd_req[k] = 1'b0;
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
